// File: rtl/div_pkg.sv
// Shared divider constants and the per-stage record of the reconstruct pipeline.
// RECON_CHECK_EN adds the expected-value and illegal-tuple fields to the record.
package div_pkg;

    localparam int unsigned DIV_WIDTH         = 8;
    localparam int unsigned DIV_RECON_LATENCY = DIV_WIDTH + 1;

    typedef struct packed {
        logic                   valid;
        logic [DIV_WIDTH-1:0]   quotient;
        logic [DIV_WIDTH-1:0]   divisor;
        logic [2*DIV_WIDTH-1:0] acc;
`ifdef RECON_CHECK_EN
        logic [DIV_WIDTH-1:0]   expected;
        logic                   illegal;
`endif
    } recon_stage_t;

endpackage

// File: rtl/div_reconstruct_stage.sv
// One registered conditional shift-add step: adds divisor << BIT_IDX when
// quotient bit BIT_IDX is set; every other field passes through unchanged.
module div_reconstruct_stage
    import div_pkg::*;
#(
    parameter int unsigned BIT_IDX = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  recon_stage_t stage_in,
    output recon_stage_t stage_out
);

    logic [2*DIV_WIDTH-1:0] addend;

    always_comb begin
        addend = {{DIV_WIDTH{1'b0}}, stage_in.divisor} << BIT_IDX;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_out <= '0;
        end else begin
            stage_out <= stage_in;
            if (stage_in.quotient[BIT_IDX]) begin
                stage_out.acc <= stage_in.acc + addend;
            end
        end
    end

endmodule

// File: rtl/div_reconstruct_pipeline.sv
// Pipelined result = quotient*divisor + remainder, latency WIDTH+1, one op per cycle.
// Optional RECON_CHECK_EN adds an expected input and a registered mismatch flag.
module div_reconstruct_pipeline
    import div_pkg::*;
#(
    // Stage record fields are sized by DIV_WIDTH; WIDTH must equal it.
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   quotient,
    input  logic [WIDTH-1:0]   divisor,
    input  logic [WIDTH-1:0]   remainder,
`ifdef RECON_CHECK_EN
    input  logic [WIDTH-1:0]   expected,
    output logic               mismatch,
`endif
    output logic               valid,
    output logic [2*WIDTH-1:0] result
);

    recon_stage_t load_q;
    recon_stage_t chain [WIDTH+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            load_q <= '0;
        end else begin
            load_q.valid <= start;
            if (start) begin
                load_q.quotient <= quotient;
                load_q.divisor  <= divisor;
                load_q.acc      <= {{WIDTH{1'b0}}, remainder};
`ifdef RECON_CHECK_EN
                load_q.expected <= expected;
                load_q.illegal  <= (divisor != '0) && (remainder >= divisor);
`endif
            end
        end
    end

    assign chain[0] = load_q;

    for (genvar k = 1; k <= WIDTH; k++) begin : g_stage
        div_reconstruct_stage #(
            .BIT_IDX(k - 1)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .stage_in (chain[k-1]),
            .stage_out(chain[k])
        );
    end

    // Result is forced to zero between pulses so stale accumulators never leak out.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid  <= 1'b0;
            result <= '0;
        end else begin
            valid  <= chain[WIDTH].valid;
            result <= chain[WIDTH].valid ? chain[WIDTH].acc : '0;
        end
    end

`ifdef RECON_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch <= 1'b0;
        end else begin
            mismatch <= chain[WIDTH].valid &&
                        ((chain[WIDTH].acc != {{WIDTH{1'b0}}, chain[WIDTH].expected}) ||
                         chain[WIDTH].illegal);
        end
    end
`endif

endmodule

// File: tb/tb_div_reconstruct_pipeline.sv
// Directed bench for div_reconstruct_pipeline; hand-computed results are queued
// into a latency model and compared against the DUT every cycle.
module tb_div_reconstruct_pipeline;
    import div_pkg::*;

    localparam int unsigned LAT = DIV_RECON_LATENCY;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  q;
    logic [7:0]  d;
    logic [7:0]  r;
    logic        valid;
    logic [15:0] result;
    logic [15:0] exp_res;
    logic [7:0]  exp_in;
    logic        exp_mis;
`ifdef RECON_CHECK_EN
    logic        mismatch;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [LAT:0]       mv;
    logic [LAT:0][15:0] mr;
    logic [LAT:0]       mm;

    // 10 directed tuples and their hand-computed q*d+r.
    logic [7:0]  tq [10] = '{8'h12, 8'h03, 8'h80, 8'h01, 8'hAA, 8'h10, 8'h55, 8'h7F, 8'h64, 8'hC8};
    logic [7:0]  td [10] = '{8'h34, 8'h05, 8'h80, 8'hFF, 8'h02, 8'h10, 8'h03, 8'h81, 8'h0A, 8'h0C};
    logic [7:0]  tr [10] = '{8'h05, 8'h02, 8'h10, 8'h00, 8'h01, 8'h0F, 8'h02, 8'h40, 8'h09, 8'h0B};
    logic [15:0] tres [10] = '{16'h03AD, 16'h0011, 16'h4010, 16'h00FF, 16'h0155,
                               16'h010F, 16'h0101, 16'h403F, 16'h03F1, 16'h096B};

    always #5 clk = ~clk;

    div_reconstruct_pipeline #(
        .WIDTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .quotient (q),
        .divisor  (d),
        .remainder(r),
`ifdef RECON_CHECK_EN
        .expected (exp_in),
        .mismatch (mismatch),
`endif
        .valid    (valid),
        .result   (result)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    task automatic drive(input logic s, input logic [7:0] qq, input logic [7:0] dd,
                         input logic [7:0] rr, input logic [15:0] er, input logic [7:0] ex,
                         input logic em);
        @(posedge clk);
        #1;
        start   = s;
        q       = qq;
        d       = dd;
        r       = rr;
        exp_res = er;
        exp_in  = ex;
        exp_mis = em;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 16'h0, 8'($urandom), 1'b0);
        end
    endtask

    // Latency model: an op sampled at edge N must appear after edge N+LAT.
    always @(posedge clk) begin
        if (reset) begin
            mv <= '0;
            mr <= '0;
            mm <= '0;
        end else begin
            mv <= {mv[LAT-1:0], start};
            mr <= {mr[LAT-1:0], (start ? exp_res : 16'h0)};
            mm <= {mm[LAT-1:0], (start ? exp_mis : 1'b0)};
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("valid", {31'b0, valid}, {31'b0, mv[LAT]});
            check_eq("result", {16'b0, result}, {16'b0, mr[LAT]});
`ifdef RECON_CHECK_EN
            check_eq("mismatch", {31'b0, mismatch}, {31'b0, mm[LAT]});
`endif
        end
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        q       = '0;
        d       = '0;
        r       = '0;
        exp_res = '0;
        exp_in  = '0;
        exp_mis = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        idle(20);

        // Basic op; expected=0 forces a mismatch flag on nonzero results.
        drive(1'b1, 8'h0D, 8'h07, 8'h05, 16'h0060, 8'h00, 1'b1);
        idle(12);

        drive(1'b1, 8'hFF, 8'hFF, 8'hFE, 16'hFEFF, 8'h00, 1'b1);
        drive(1'b1, 8'hFF, 8'hFF, 8'hFF, 16'hFF00, 8'h00, 1'b1);
        drive(1'b1, 8'h00, 8'hAB, 8'h3C, 16'h003C, 8'h00, 1'b1);
        drive(1'b1, 8'hFF, 8'h00, 8'h99, 16'h0099, 8'h00, 1'b1);
        idle(12);

        // 8 back-to-back, 3-cycle gap, 2 more.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tq[i], td[i], tr[i], tres[i], 8'h00, 1'b1);
        end
        idle(3);
        for (int i = 8; i < 10; i++) begin
            drive(1'b1, tq[i], td[i], tr[i], tres[i], 8'h00, 1'b1);
        end
        idle(12);

        // Three ops, reset on the fourth edge after the first; start there is ignored.
        drive(1'b1, 8'h12, 8'h34, 8'h05, 16'h03AD, 8'h00, 1'b1);
        drive(1'b1, 8'h03, 8'h05, 8'h02, 16'h0011, 8'h00, 1'b1);
        drive(1'b1, 8'h80, 8'h80, 8'h10, 16'h4010, 8'h00, 1'b1);
        idle(1);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        start   = 1'b1;
        q       = 8'h55;
        d       = 8'h03;
        r       = 8'h02;
        exp_res = 16'h0101;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        idle(12);
        drive(1'b1, 8'h64, 8'h0A, 8'h09, 16'h03F1, 8'h00, 1'b1);
        idle(12);

        // Consistency-check cases.
        drive(1'b1, 8'h0D, 8'h07, 8'h05, 16'h0060, 8'h60, 1'b0);
        drive(1'b1, 8'h0D, 8'h07, 8'h05, 16'h0060, 8'h5F, 1'b1);
        drive(1'b1, 8'hFF, 8'h00, 8'h42, 16'h0042, 8'h42, 1'b0);
        drive(1'b1, 8'h01, 8'h03, 8'h04, 16'h0007, 8'h07, 1'b1);
        idle(14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
